// File: rtl/layer_generator.sv
// -----------------------------------------------------------------------------
// layer_generator
//
// Builds the next row of the block field (occupancy map plus hazard map) and
// holds it stable until a jump consumes it. Every row keeps one non-hazard
// block exactly one column left or right of the previous row's safe block, so
// a survivable jump always exists. Hazard density rises with the number of
// rows consumed.
//
// Optional feature (macro SKYHOP_SEED_IN_EN):
//   defined   - adds input seed_in[15:0]; the LFSR loads it on every reset
//               cycle, with seed_in = 0 replaced by LFSR_SEED.
//   undefined - no seed_in port; the LFSR always loads LFSR_SEED.
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous, active-high reset
//   module_en      in   0 behaves exactly as rst
//   jump_left      in   single-cycle consume pulse
//   jump_right     in   single-cycle consume pulse
//   seed_in        in   [15:0] reset seed (only with SKYHOP_SEED_IN_EN)
//   layer_map_out  out  [0:6] staged row occupancy, bit 0 = leftmost column
//   block_type_out out  [0:6] 1 = hazard; always a subset of layer_map_out
//   row_ready      out  staged row is valid
//   row_count      out  [7:0] rows consumed, saturates at 255
//   level          out  [1:0] difficulty level 0..2
//   overrun        out  sticky; set when a jump arrives with row_ready = 0
//
// Handshake: the consumer samples layer_map_out/block_type_out in the same
// cycle it raises jump_left/jump_right while row_ready = 1. A jump while
// row_ready = 0 is dropped and flags overrun. Both jumps together count as
// a single consume.
// -----------------------------------------------------------------------------
module layer_generator #(
    parameter int          GEN_CYCLES  = 3,
    parameter int          START_COL   = 3,
    parameter int          WARMUP_ROWS = 4,
    parameter int          LEVEL_ROWS  = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       module_en,
    input  logic       jump_left,
    input  logic       jump_right,
`ifdef SKYHOP_SEED_IN_EN
    input  logic [15:0] seed_in,
`endif
    output logic [0:6] layer_map_out,
    output logic [0:6] block_type_out,
    output logic       row_ready,
    output logic [7:0] row_count,
    output logic [1:0] level,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [7:0] GEN_LAST = 8'(GEN_CYCLES - 1);
    localparam logic [7:0] LVL_LAST = 8'(LEVEL_ROWS - 1);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  gen_cnt;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_next;
    logic [15:0] reset_seed;
    logic [2:0]  path_col;
    logic [2:0]  np_q;
    logic [2:0]  np_c;
    logic [0:6]  occ_q;
    logic [0:6]  occ_c;
    logic [0:6]  hz_q;
    logic [0:6]  hz_c;
    logic [7:0]  lvl_cnt;
    logic        sync_rst;
    logic        consume;
    logic        hz_off;

    assign sync_rst  = rst | ~module_en;
    assign consume   = jump_left | jump_right;
    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

`ifdef SKYHOP_SEED_IN_EN
    assign reset_seed = (seed_in == 16'h0000) ? LFSR_SEED : seed_in;
`else
    assign reset_seed = LFSR_SEED;
`endif

    // Next safe column: one step from the previous one, reflected at the edges.
    always_comb begin
        if (path_col == 3'd0) begin
            np_c = 3'd1;
        end else if (path_col == 3'd6) begin
            np_c = 3'd5;
        end else if (lfsr_q[0]) begin
            np_c = path_col + 3'd1;
        end else begin
            np_c = path_col - 3'd1;
        end
    end

    // Column c draws its random bits from lfsr[c] (occupancy / rawB) and
    // lfsr[7+c] (rawA). The safe column is always occupied and never a hazard.
    assign hz_off = (level == 2'd0) || (int'(row_count) < WARMUP_ROWS);

    always_comb begin
        occ_c = '0;
        hz_c  = '0;
        for (int c = 0; c < 7; c++) begin
            occ_c[c] = lfsr_q[c] | (np_q == 3'(c));
            if (!hz_off) begin
                if (level == 2'd1) begin
                    hz_c[c] = occ_q[c] & (np_q != 3'(c)) & lfsr_q[7 + c] & lfsr_q[c];
                end else begin
                    hz_c[c] = occ_q[c] & (np_q != 3'(c)) & lfsr_q[7 + c];
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = GEN;
            GEN:     if (gen_cnt == GEN_LAST) state_d = READY;
            READY:   if (consume) state_d = GEN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q        <= IDLE;
            gen_cnt        <= '0;
            lfsr_q         <= reset_seed;
            path_col       <= 3'(START_COL);
            np_q           <= '0;
            occ_q          <= '0;
            hz_q           <= '0;
            lvl_cnt        <= '0;
            layer_map_out  <= '0;
            block_type_out <= '0;
            row_ready      <= 1'b0;
            row_count      <= '0;
            level          <= '0;
            overrun        <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_next;
            state_q <= state_d;

            case (state_q)
                IDLE: begin
                    gen_cnt <= '0;
                end
                GEN: begin
                    gen_cnt <= gen_cnt + 8'd1;
                    if (gen_cnt == 8'd0) np_q  <= np_c;
                    if (gen_cnt == 8'd1) occ_q <= occ_c;
                    if (gen_cnt == 8'd2) hz_q  <= hz_c;
                    if (gen_cnt == GEN_LAST) begin
                        layer_map_out <= occ_q;
                        // With the minimum GEN length the hazard cycle is also
                        // the exit cycle, so take the hazards straight through.
                        block_type_out <= (gen_cnt == 8'd2) ? hz_c : hz_q;
                        path_col       <= np_q;
                        row_ready      <= 1'b1;
                    end
                end
                READY: begin
                    if (consume) begin
                        gen_cnt   <= '0;
                        row_ready <= 1'b0;
                        if (row_count != 8'hFF) begin
                            row_count <= row_count + 8'd1;
                            if (lvl_cnt == LVL_LAST) begin
                                lvl_cnt <= '0;
                                if (level < 2'd2) level <= level + 2'd1;
                            end else begin
                                lvl_cnt <= lvl_cnt + 8'd1;
                            end
                        end
                    end
                end
                default: begin
                    gen_cnt <= '0;
                end
            endcase

            if (consume && (state_q != READY)) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_layer_generator.sv
`timescale 1ns/1ps
module tb_layer_generator;

  localparam int          GEN_CYCLES  = 3;
  localparam int          START_COL   = 3;
  localparam int          WARMUP_ROWS = 4;
  localparam int          LEVEL_ROWS  = 8;
  localparam logic [15:0] SEED        = 16'hACE1;
  localparam int          N_OPEN      = 6;

  typedef struct packed {
    logic [0:6] map;
    logic [0:6] typ;
    logic [2:0] np;
    logic [7:0] cnt;
    logic [1:0] lvl;
  } row_t;
  localparam int ROW_W = $bits(row_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst, module_en, jump_left, jump_right;
  always #5 clk = ~clk;

  logic [0:6] map, typ, lo_map, lo_typ, hi_map, hi_typ;
  logic       rr, ovr, lo_rr, lo_ovr, hi_rr, hi_ovr;
  logic [7:0] cnt, lo_cnt, hi_cnt;
  logic [1:0] lvl, lo_lvl, hi_lvl;

  layer_generator #(.GEN_CYCLES(GEN_CYCLES), .START_COL(START_COL), .WARMUP_ROWS(WARMUP_ROWS),
                    .LEVEL_ROWS(LEVEL_ROWS), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .module_en(module_en), .jump_left(jump_left), .jump_right(jump_right),
`ifdef SKYHOP_SEED_IN_EN
    .seed_in(16'h0000),
`endif
    .layer_map_out(map), .block_type_out(typ), .row_ready(rr), .row_count(cnt),
    .level(lvl), .overrun(ovr));

  layer_generator #(.START_COL(0), .LFSR_SEED(SEED)) dut_lo (
    .clk(clk), .rst(rst), .module_en(module_en), .jump_left(jump_left), .jump_right(jump_right),
`ifdef SKYHOP_SEED_IN_EN
    .seed_in(16'h0000),
`endif
    .layer_map_out(lo_map), .block_type_out(lo_typ), .row_ready(lo_rr), .row_count(lo_cnt),
    .level(lo_lvl), .overrun(lo_ovr));

  layer_generator #(.START_COL(6), .LFSR_SEED(SEED)) dut_hi (
    .clk(clk), .rst(rst), .module_en(module_en), .jump_left(jump_left), .jump_right(jump_right),
`ifdef SKYHOP_SEED_IN_EN
    .seed_in(16'h0000),
`endif
    .layer_map_out(hi_map), .block_type_out(hi_typ), .row_ready(hi_rr), .row_count(hi_cnt),
    .level(hi_lvl), .overrun(hi_ovr));

  // ---------------- reference model ----------------
  logic [15:0] m_lfsr;
  logic [2:0]  m_path;
  logic [7:0]  m_cnt;
  logic [1:0]  m_lvl;
  logic        m_ovr;
  logic [0:6]  prev_map, prev_typ;
  logic [0:6]  first_map [N_OPEN];
  logic [0:6]  first_typ [N_OPEN];
  int          row_idx;
  bit          rec_mode, cmp_mode;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // cur = LFSR value in the cycle just before GEN cycle 0.
  function automatic row_t model_row(input logic [15:0] cur, input logic [2:0] path,
                                     input logic [7:0] rc, input logic [1:0] lv);
    logic [15:0] s0, s1, s2;
    logic [2:0]  np;
    row_t        r;
    s0 = lfsr_step(cur);
    s1 = lfsr_step(s0);
    s2 = lfsr_step(s1);
    if (path == 3'd0)      np = 3'd1;
    else if (path == 3'd6) np = 3'd5;
    else if (s0[0])        np = path + 3'd1;
    else                   np = path - 3'd1;
    for (int c = 0; c < 7; c++) begin
      r.map[c] = s1[c] | (3'(c) == np);
      if (lv == 2'd0 || int'(rc) < WARMUP_ROWS) r.typ[c] = 1'b0;
      else if (lv == 2'd1) r.typ[c] = r.map[c] & (3'(c) != np) & s2[7 + c] & s2[c];
      else                 r.typ[c] = r.map[c] & (3'(c) != np) & s2[7 + c];
    end
    r.np  = np;
    r.cnt = rc;
    r.lvl = lv;
    return r;
  endfunction

  // Model LFSR tracks the DUT LFSR value within each cycle.
  always @(posedge clk) begin
    if (rst || !module_en) m_lfsr <= SEED;
    else                   m_lfsr <= lfsr_step(m_lfsr);
  end

  // ---------------- scoreboard ----------------
  logic [ROW_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_row();
    row_t r;
    r = model_row(m_lfsr, m_path, m_cnt, m_lvl);
    exp_q.push_back(r);
  endtask

  // Called one step past a posedge; waits for the staged row and scores it.
  task automatic wait_row(input int exp_lat);
    int   n;
    bit   got;
    int   p;
    logic safe_ok;
    row_t r;
    n = 0;
    got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (rr) got = 1;
      else begin
        check("gen_hold_map", map, prev_map);
        check("gen_hold_type", typ, prev_typ);
      end
    end
    if (!got) begin
      check("row_ready_timeout", rr, 1);
      return;
    end
    check("ready_latency", n, exp_lat);
    if (exp_q.size() == 0) begin
      check("exp_q_size", exp_q.size(), 1);
      return;
    end
    r = row_t'(exp_q.pop_front());
    check("layer_map", map, r.map);
    check("block_type", typ, r.typ);
    check("row_count", cnt, r.cnt);
    check("level", lvl, r.lvl);
    check("overrun", ovr, m_ovr);
    check("type_subset", typ & ~map, 0);
    p = int'(m_path);
    safe_ok = ((p > 0) && map[p - 1] && !typ[p - 1]) || ((p < 6) && map[p + 1] && !typ[p + 1]);
    check("safe_adjacent", safe_ok, 1);
    if (row_idx < N_OPEN) begin
      if (rec_mode) begin
        first_map[row_idx] = map;
        first_typ[row_idx] = typ;
      end else if (cmp_mode) begin
        check("rerun_map", map, first_map[row_idx]);
        check("rerun_type", typ, first_typ[row_idx]);
      end
    end
    row_idx++;
    m_path   = r.np;
    prev_map = r.map;
    prev_typ = r.typ;
  endtask

  // ---------------- driver tasks ----------------
  task automatic release_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    module_en = 1'b1;
    m_path = 3'(START_COL);
    m_cnt = '0;
    m_lvl = '0;
    m_ovr = 1'b0;
    prev_map = '0;
    prev_typ = '0;
    row_idx = 0;
    push_row();
    @(negedge clk);
    check("idle_row_ready", rr, 0);
    @(posedge clk); #1;
    wait_row(GEN_CYCLES + 1);
  endtask

  task automatic consume(input logic l, input logic r, input bit double_pulse);
    int q;
    @(posedge clk); #1;
    jump_left = l;
    jump_right = r;
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    q = int'(m_cnt) / LEVEL_ROWS;
    m_lvl = (q >= 2) ? 2'd2 : 2'(q);
    push_row();
    @(posedge clk); #1;
    jump_left = 1'b0;
    jump_right = 1'b0;
    if (double_pulse) begin
      @(posedge clk); #1;
      jump_right = 1'b1;
      m_ovr = 1'b1;
      @(posedge clk); #1;
      jump_right = 1'b0;
      wait_row(GEN_CYCLES - 1);
    end else begin
      wait_row(GEN_CYCLES + 1);
    end
  endtask

  task automatic opening_sequence();
    release_reset();
    consume(1'b0, 1'b1, 1'b1);
    consume(1'b1, 1'b0, 1'b0);
    consume(1'b0, 1'b1, 1'b0);
    consume(1'b1, 1'b1, 1'b0);
    consume(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    row_t lo_r, hi_r;
    int   k, d;
    rst = 1'b1;
    module_en = 1'b1;
    jump_left = 1'b0;
    jump_right = 1'b0;
    rec_mode = 1'b1;
    cmp_mode = 1'b0;
    m_path = 3'(START_COL);
    m_cnt = '0;
    m_lvl = '0;
    m_ovr = 1'b0;
    row_idx = 0;
    prev_map = '0;
    prev_typ = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_map", map, 0);
    check("rst_type", typ, 0);
    check("rst_ready", rr, 0);
    check("rst_count", cnt, 0);
    check("rst_level", lvl, 0);
    check("rst_overrun", ovr, 0);

    // First run: first row plus the edge-column instances, then the opening rows.
    release_reset();
    lo_r = model_row(SEED, 3'd0, 8'd0, 2'd0);
    hi_r = model_row(SEED, 3'd6, 8'd0, 2'd0);
    check("first_row_type_warmup", typ, 0);
    check("first_safe_col", (map[2] && !typ[2]) || (map[4] && !typ[4]), 1);
    check("lo_ready", lo_rr, 1);
    check("lo_map", lo_map, lo_r.map);
    check("lo_safe_col1", lo_map[1] && !lo_typ[1], 1);
    check("hi_ready", hi_rr, 1);
    check("hi_map", hi_map, hi_r.map);
    check("hi_safe_col5", hi_map[5] && !hi_typ[5], 1);
    consume(1'b0, 1'b1, 1'b1);
    consume(1'b1, 1'b0, 1'b0);
    consume(1'b0, 1'b1, 1'b0);
    consume(1'b1, 1'b1, 1'b0);
    consume(1'b1, 1'b0, 1'b0);
    rec_mode = 1'b0;

    // Long random run: levels 1 and 2, edge reflection, count saturation.
    for (int i = 0; i < 2000; i++) begin
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) begin
        @(negedge clk);
        check("ready_hold_map", map, prev_map);
        check("ready_hold_rdy", rr, 1);
      end
      d = $urandom_range(1, 3);
      consume(d[0], d[1], 1'b0);
    end
    check("sat_count", cnt, 255);
    check("sat_level", lvl, 2);

    // Disable mid-GEN: row is abandoned and outputs clear on the next cycle.
    @(posedge clk); #1;
    jump_right = 1'b1;
    @(posedge clk); #1;
    jump_right = 1'b0;
    @(posedge clk); #1;
    module_en = 1'b0;
    @(negedge clk);
    check("pre_disable_hold", map, prev_map);
    @(negedge clk);
    check("dis_map", map, 0);
    check("dis_type", typ, 0);
    check("dis_ready", rr, 0);
    check("dis_count", cnt, 0);
    check("dis_level", lvl, 0);
    check("dis_overrun", ovr, 0);
    exp_q.delete();

    // Re-enable with the same seed and stimulus: rows must repeat.
    cmp_mode = 1'b1;
    opening_sequence();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
